read_merge: RTL and testbench

Downstream companion to the memory-stage input aligner. Each aligner request may be split across two 16-byte cache lines. For every such request, this block queues a descriptor holding the byte offset, size and PTC tag. It then collects the line-0 and line-1 read data from the cache banks, which may return in either order and on different cycles. It funnels the requested bytes into a right-justified 64-bit result and presents that result to the writeback side with a valid/ready handshake.

---
 rtl/read_merge_pkg.sv | 42 ++++
 rtl/read_merge_merge_shift.sv | 37 +++
 rtl/read_merge.sv | 227 ++++++++++++++++++++++
 tb/tb_read_merge.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/read_merge_pkg.sv
// Shared memory-stage types: size codes, byte-count helper, head FSM states
// and the queued read-merge descriptor.
package read_merge_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] offset;
        logic [1:0] size;
        logic       split;
        logic [6:0] tag;
    } desc_t;

    function automatic logic [3:0] nbytes(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            SIZE_BYTE:  n = 4'd1;
            SIZE_HALF:  n = 4'd2;
            SIZE_WORD:  n = 4'd4;
            SIZE_DWORD: n = 4'd8;
            default:    n = 4'd8;
        endcase
        return n;
    endfunction

    // An access is split when its last byte falls beyond byte 15 of line 0.
    function automatic logic is_split(input logic [3:0] offset, input logic [1:0] size);
        logic [4:0] last;
        last = {1'b0, offset} + {1'b0, nbytes(size)} - 5'd1;
        return (last > 5'd15);
    endfunction

endpackage

// File: rtl/read_merge_merge_shift.sv
// Combinational byte funnel: right-shifts a two-line window by a byte offset
// and zeroes every byte at or above the access size.
module merge_shift
    import read_merge_pkg::*;
(
    input  logic [255:0] data_in,
    input  logic [3:0]   offset,
    input  logic [1:0]   size,
    output logic [63:0]  data_out
);

    logic [175:0] s1_s;
    logic [159:0] s2_s;
    logic [127:0] s3_s;
    logic [63:0]  s4_s;
    logic [3:0]   n_s;

    // Each level is only as wide as the bytes later levels can still reach.
    assign s1_s = offset[0] ? data_in[183:8] : data_in[175:0];
    assign s2_s = offset[1] ? s1_s[175:16]   : s1_s[159:0];
    assign s3_s = offset[2] ? s2_s[159:32]   : s2_s[127:0];
    assign s4_s = offset[3] ? s3_s[127:64]   : s3_s[63:0];
    assign n_s  = nbytes(size);

    // Size mask: keep bytes below nbytes, zero the rest.
    always_comb begin
        data_out = 64'h0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n_s) begin
                data_out[8*i +: 8] = s4_s[8*i +: 8];
            end else begin
                data_out[8*i +: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/read_merge.sv
// Queues split-line read descriptors, collects line-0/line-1 data in either
// order and presents a right-justified merged result over valid/ready.
module read_merge
    import read_merge_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_offset,
    input  logic [1:0]   req_size,
    input  logic [6:0]   req_tag,
    input  logic         d0_valid,
    input  logic [127:0] d0_data,
    input  logic         d1_valid,
    input  logic [127:0] d1_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic [6:0]   out_tag,
    output logic [1:0]   out_size,
    output logic         busy,
    output logic         proto_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    desc_t              queue_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   count_r, cnt_s;
    state_e             state_r, state_s, state_c_s;
    logic               have0_r, have1_r, have0_s, have1_s;
    logic [127:0]       d0_r, d1_r, m0_s, m1_s;
    logic               push_s, pop_s, cap0_s, cap1_s, err_s, go_c_s, go_ready_s;
    desc_t              head_s, desc_s;
    logic [63:0]        merged_s;
    logic               req_ready_r, out_valid_r, busy_r, proto_err_r;
    logic [63:0]        out_data_r;
    logic [6:0]         out_tag_r;
    logic [1:0]         out_size_r;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_s = queue_r[rd_ptr_r];
    assign desc_s = '{offset: req_offset, size: req_size,
                      split: is_split(req_offset, req_size), tag: req_tag};
    // req_ready is registered, so a same-cycle pop never frees a slot for a push.
    assign push_s = req_valid && req_ready_r && !flush;
    assign pop_s  = (state_r == READY) && out_ready && !flush;

    // Next occupancy, cleared by flush.
    always_comb begin
        cnt_s = count_r;
        if (flush) begin
            cnt_s = '0;
        end else begin
            cnt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Head FSM next state, half capture and protocol-error detection.
    always_comb begin
        state_c_s = state_r;
        cap0_s    = 1'b0;
        cap1_s    = 1'b0;
        err_s     = 1'b0;
        go_c_s    = 1'b0;
        have0_s   = have0_r;
        have1_s   = have1_r;
        case (state_r)
            EMPTY: begin
                err_s = d0_valid | d1_valid;
                if (push_s || (count_r != '0)) begin
                    state_c_s = COLLECT;
                end else begin
                    state_c_s = EMPTY;
                end
            end
            COLLECT: begin
                if (d0_valid) begin
                    if (have0_r) begin
                        err_s = 1'b1;
                    end else begin
                        cap0_s = 1'b1;
                    end
                end else begin
                    cap0_s = 1'b0;
                end
                if (d1_valid) begin
                    if (!head_s.split || have1_r) begin
                        err_s = 1'b1;
                    end else begin
                        cap1_s = 1'b1;
                    end
                end else begin
                    cap1_s = 1'b0;
                end
                have0_s = have0_r | cap0_s;
                have1_s = have1_r | cap1_s;
                if (have0_s && (!head_s.split || have1_s)) begin
                    go_c_s    = 1'b1;
                    state_c_s = READY;
                end else begin
                    state_c_s = COLLECT;
                end
            end
            READY: begin
                err_s = d0_valid | d1_valid;
                if (pop_s) begin
                    state_c_s = (cnt_s != '0) ? COLLECT : EMPTY;
                end else begin
                    state_c_s = READY;
                end
            end
            default: state_c_s = EMPTY;
        endcase
    end

    assign state_s    = flush ? EMPTY : state_c_s;
    assign go_ready_s = go_c_s && !flush;

    // Merge from this cycle's arriving halves so the result registers with no extra stage.
    assign m0_s = cap0_s ? d0_data : d0_r;
    assign m1_s = head_s.split ? (cap1_s ? d1_data : d1_r) : 128'h0;

    merge_shift u_merge_shift (
        .data_in  ({m1_s, m0_s}),
        .offset   (head_s.offset),
        .size     (head_s.size),
        .data_out (merged_s)
    );

    // Descriptor queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                queue_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                queue_r[wr_ptr_r] <= desc_s;
                wr_ptr_r          <= inc_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= inc_ptr(rd_ptr_r);
            end
            count_r <= cnt_s;
        end
    end

    // Head state and collected halves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= EMPTY;
            have0_r <= 1'b0;
            have1_r <= 1'b0;
            d0_r    <= 128'h0;
            d1_r    <= 128'h0;
        end else begin
            state_r <= state_s;
            if (flush || pop_s) begin
                have0_r <= 1'b0;
                have1_r <= 1'b0;
            end else begin
                have0_r <= have0_s;
                have1_r <= have1_s;
            end
            if (cap0_s) begin
                d0_r <= d0_data;
            end
            if (cap1_s) begin
                d1_r <= d1_data;
            end
        end
    end

    // Registered outputs and the sticky protocol-error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            proto_err_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 64'h0;
            out_tag_r   <= 7'h0;
            out_size_r  <= 2'h0;
        end else begin
            req_ready_r <= (cnt_s < DEPTH_C);
            busy_r      <= (cnt_s != '0);
            proto_err_r <= proto_err_r | err_s;
            if (flush) begin
                out_valid_r <= 1'b0;
            end else if (go_ready_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= merged_s;
                out_tag_r   <= head_s.tag;
                out_size_r  <= head_s.size;
            end else if (pop_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_tag   = out_tag_r;
    assign out_size  = out_size_r;
    assign busy      = busy_r;
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_read_merge.sv
// Directed bench for read_merge: unsplit/split merges, backpressure,
// protocol errors, flush and asynchronous reset.
module tb_read_merge;

    logic         clk = 1'b0;
    logic         rst, flush, req_valid, req_ready;
    logic [3:0]   req_offset;
    logic [1:0]   req_size;
    logic [6:0]   req_tag;
    logic         d0_valid, d1_valid, out_valid, out_ready, busy, proto_err;
    logic [127:0] d0_data, d1_data;
    logic [63:0]  out_data;
    logic [6:0]   out_tag;
    logic [1:0]   out_size;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] IDX  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] HI   = 128'h1f1e1d1c1b1a19181716151413121110;
    localparam logic [127:0] JUNK = 128'hdeadbeefcafef00d5a5aa5a5c3c33c3c;

    read_merge #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_offset(req_offset),
        .req_size(req_size), .req_tag(req_tag),
        .d0_valid(d0_valid), .d0_data(d0_data), .d1_valid(d1_valid), .d1_data(d1_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_size(out_size), .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] off, input logic [1:0] sz, input logic [6:0] tg);
        req_valid  = 1'b1;
        req_offset = off;
        req_size   = sz;
        req_tag    = tg;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic send0(input logic [127:0] d);
        d0_valid = 1'b1;
        d0_data  = d;
        tick();
        d0_valid = 1'b0;
    endtask

    task automatic send1(input logic [127:0] d);
        d1_valid = 1'b1;
        d1_data  = d;
        tick();
        d1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; req_valid = 1'b0; req_offset = 4'h0; req_size = 2'h0;
        req_tag = 7'h0; d0_valid = 1'b0; d1_valid = 1'b0; d0_data = 128'h0; d1_data = 128'h0;
        out_ready = 1'b0;
        tick(); tick();
        chk("rst_req_ready", 64'(req_ready), 64'h1);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data",  out_data,       64'h0);
        chk("rst_busy",      64'(busy),      64'h0);
        chk("rst_proto_err", 64'(proto_err), 64'h0);
        rst = 1'b1;

        // Unsplit read, offset 4, 4 bytes
        push(4'd4, 2'd2, 7'h15);
        chk("t1_busy", 64'(busy), 64'h1);
        chk("t1_ready_one_used", 64'(req_ready), 64'h1);
        chk("t1_valid_before", 64'(out_valid), 64'h0);
        send0(IDX);
        chk("t1_valid", 64'(out_valid), 64'h1);
        chk("t1_data",  out_data, 64'h0000000007060504);
        chk("t1_tag",   64'(out_tag), 64'h15);
        chk("t1_size",  64'(out_size), 64'h2);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t1_pop_valid", 64'(out_valid), 64'h0);
        chk("t1_pop_busy",  64'(busy), 64'h0);

        // Split read, d1 two cycles before d0
        push(4'd13, 2'd3, 7'h2a);
        send1(HI);
        tick();
        chk("t2_valid_wait", 64'(out_valid), 64'h0);
        send0(IDX);
        chk("t2_valid", 64'(out_valid), 64'h1);
        chk("t2_data",  out_data, 64'h14131211100f0e0d);
        chk("t2_tag",   64'(out_tag), 64'h2a);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Backpressure with a full queue
        push(4'd0, 2'd3, 7'h01);
        push(4'd8, 2'd1, 7'h02);
        chk("t3_full_ready", 64'(req_ready), 64'h0);
        send0(IDX);
        repeat (5) tick();
        chk("t3_hold_valid", 64'(out_valid), 64'h1);
        chk("t3_hold_data",  out_data, 64'h0706050403020100);
        chk("t3_hold_tag",   64'(out_tag), 64'h01);
        chk("t3_hold_ready", 64'(req_ready), 64'h0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t3_release_valid", 64'(out_valid), 64'h0);
        chk("t3_release_ready", 64'(req_ready), 64'h1);
        send0(IDX);
        chk("t3_b_valid", 64'(out_valid), 64'h1);
        chk("t3_b_data",  out_data, 64'h0000000000000908);
        chk("t3_b_tag",   64'(out_tag), 64'h02);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t3_no_err", 64'(proto_err), 64'h0);

        // Protocol errors: d0 while EMPTY, then d1 for an unsplit head
        send0(JUNK);
        chk("t4_err_empty", 64'(proto_err), 64'h1);
        chk("t4_empty_busy", 64'(busy), 64'h0);
        push(4'd2, 2'd0, 7'h03);
        send1(JUNK);
        chk("t4_d1_dropped", 64'(out_valid), 64'h0);
        send0(IDX);
        chk("t4_valid", 64'(out_valid), 64'h1);
        chk("t4_data",  out_data, 64'h0000000000000002);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Flush in COLLECT with have0 set and a second entry queued
        push(4'd12, 2'd3, 7'h04);
        req_valid = 1'b1; req_offset = 4'd0; req_size = 2'd2; req_tag = 7'h05;
        d0_valid = 1'b1; d0_data = IDX;
        tick();
        req_valid = 1'b0; d0_valid = 1'b0;
        chk("t5_pre_valid", 64'(out_valid), 64'h0);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t5_busy",  64'(busy), 64'h0);
        chk("t5_valid", 64'(out_valid), 64'h0);
        chk("t5_ready", 64'(req_ready), 64'h1);
        push(4'd1, 2'd1, 7'h06);
        send0(IDX);
        chk("t5_new_valid", 64'(out_valid), 64'h1);
        chk("t5_new_data",  out_data, 64'h0000000000000201);
        chk("t5_new_tag",   64'(out_tag), 64'h06);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Asynchronous reset mid-COLLECT, between edges
        push(4'd15, 2'd1, 7'h07);
        send0(IDX);
        chk("t6_pre_busy", 64'(busy), 64'h1);
        chk("t6_pre_err",  64'(proto_err), 64'h1);
        #2 rst = 1'b0;
        #1;
        chk("t6_req_ready", 64'(req_ready), 64'h1);
        chk("t6_out_valid", 64'(out_valid), 64'h0);
        chk("t6_out_data",  out_data, 64'h0);
        chk("t6_out_tag",   64'(out_tag), 64'h0);
        chk("t6_out_size",  64'(out_size), 64'h0);
        chk("t6_busy",      64'(busy), 64'h0);
        chk("t6_proto_err", 64'(proto_err), 64'h0);
        #1 rst = 1'b1;
        tick();

        // d1 for an unsplit head after reset
        push(4'd0, 2'd0, 7'h7f);
        send1(JUNK);
        chk("t7_err_d1", 64'(proto_err), 64'h1);
        chk("t7_d1_dropped", 64'(out_valid), 64'h0);
        send0(~IDX);
        chk("t7_data", out_data, 64'h00000000000000ff);
        chk("t7_tag",  64'(out_tag), 64'h7f);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
